// File: rtl/csoc_uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples mid-bit LSB-first, and presents
// each good byte in a one-entry holding register with valid/ready handshake.
module csoc_uart_rx #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned TW           = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_n;
  logic          rx_meta, rx_s;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tick_c;
  logic          wr_c;
  logic          ferr_c;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  assign tick_c = (timer == '0);

  // Next-state, bit timer and shift register control
  always_comb begin
    state_n   = state;
    timer_n   = tick_c ? timer : timer - TW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    wr_c      = 1'b0;
    ferr_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          timer_n = HALF_RELOAD;
        end
      end
      S_START: begin
        if (tick_c) begin
          if (!rx_s) begin
            state_n   = S_DATA;
            timer_n   = FULL_RELOAD;
            bit_idx_n = 3'd0;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick_c) begin
          shift_n[bit_idx] = rx_s;
          bit_idx_n        = bit_idx + 3'd1;
          timer_n          = FULL_RELOAD;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_c) begin
          if (rx_s) begin
            wr_c    = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_c  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      timer   <= timer_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  // Holding register and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      frame_err_o <= ferr_c;
      overrun_o   <= wr_c && valid_o && !ready_i;
      busy_o      <= (state_n != S_IDLE);
      if (wr_c) begin
        data_o  <= shift;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
